// File: rtl/gpio_hex_display.sv
// rtl/gpio_hex_display.sv - CPU GPIO word capture shown on a multiplexed 8-digit 7-segment display
// Optional feature macro: GPIO_HEX_LZ_BLANK_EN (leading-zero blanking)
module gpio_hex_display #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned FLASH_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gpio_we,
    input  logic [31:0] gpio_wdata,
    output logic [31:0] hex_value,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic        busy_flash
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic [31:0]   hex_value_q, hex_value_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          busy_q, busy_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic [7:0]    an_n_q, an_n_d;
    logic          dp_n_q, dp_n_d;
    logic          slot_wrap;
    logic          digit_on;
    logic [3:0]    nibble;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

`ifdef GPIO_HEX_LZ_BLANK_EN
    logic [2:0] msd;

    // Highest nonzero nibble; zero value keeps digit 0 lit.
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hex_value_q[4*i +: 4] != 4'h0) begin
                msd = 3'(i);
            end
        end
    end

    assign digit_on = (state_q == ST_DRIVE) && (digit_idx_q <= msd);
`else
    assign digit_on = (state_q == ST_DRIVE);
`endif

    always_comb begin
        slot_wrap   = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + CW'(1);
        digit_idx_d = slot_wrap ? digit_idx_q + 3'd1 : digit_idx_q;

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (slot_cnt_d == BLANK_END) state_d = ST_DRIVE;
            ST_DRIVE: if (slot_wrap && BLANK_CYCLES != 0) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        hex_value_d = gpio_we ? gpio_wdata : hex_value_q;

        // A write always reloads; no accumulation across writes.
        flash_cnt_d = flash_cnt_q;
        busy_d      = busy_q;
        if (gpio_we) begin
            flash_cnt_d = FLASH_LOAD;
            busy_d      = 1'b1;
        end else if (busy_q) begin
            if (flash_cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                flash_cnt_d = flash_cnt_q - FW'(1);
            end
        end

        nibble  = hex_value_q[{digit_idx_q, 2'b00} +: 4];
        an_n_d  = digit_on ? ~(8'h01 << digit_idx_q) : 8'hFF;
        seg_n_d = digit_on ? decode(nibble) : 7'h7F;
        dp_n_d  = !((state_q == ST_DRIVE) && (digit_idx_q == 3'd0) && busy_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            slot_cnt_q  <= '0;
            digit_idx_q <= 3'd0;
            hex_value_q <= 32'h0;
            flash_cnt_q <= '0;
            busy_q      <= 1'b0;
            seg_n_q     <= 7'h7F;
            an_n_q      <= 8'hFF;
            dp_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            hex_value_q <= hex_value_d;
            flash_cnt_q <= flash_cnt_d;
            busy_q      <= busy_d;
            seg_n_q     <= seg_n_d;
            an_n_q      <= an_n_d;
            dp_n_q      <= dp_n_d;
        end
    end

    assign hex_value  = hex_value_q;
    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign dp_n       = dp_n_q;
    assign busy_flash = busy_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// tb/tb_gpio_hex_display.sv - scoreboard bench for gpio_hex_display
module tb_gpio_hex_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gpio_we;
    logic [31:0] gpio_wdata;
    logic [31:0] hex_value;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic        busy_flash;

    always #5 clk = ~clk;

    gpio_hex_display #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2),
        .FLASH_CYCLES(20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpio_we   (gpio_we),
        .gpio_wdata(gpio_wdata),
        .hex_value (hex_value),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .an_n      (an_n),
        .busy_flash(busy_flash)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } frame_t;

    frame_t exp_q[$];
    int     busy_exp_q[$];
    int     checks   = 0;
    int     failures = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected digit presentations for one full scan of value v.
    task automatic push_frame(input logic [31:0] v, input bit dp0);
        int     msd;
        frame_t f;
        msd = 7;
`ifdef GPIO_HEX_LZ_BLANK_EN
        msd = 0;
        for (int i = 1; i < 8; i++) begin
            if (v[4*i +: 4] != 4'h0) msd = i;
        end
`endif
        for (int i = 0; i <= msd; i++) begin
            f.an  = ~(8'h01 << i);
            f.seg = seg_tab[v[4*i +: 4]];
            f.dp  = (i == 0 && dp0) ? 1'b0 : 1'b1;
            exp_q.push_back(f);
        end
    endtask

    logic       mon_en    = 1'b0;
    logic [7:0] prev_an   = 8'hFF;
    logic       prev_busy = 1'b0;
    int         drive_run = 0;
    int         busy_run  = 0;
    int         busy_req;
    frame_t     mon_f;

    always @(negedge clk) begin
        if (mon_en) begin
            if (an_n != 8'hFF) begin
                if (prev_an == 8'hFF) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_digit actual an_n=%h seg_n=%h required no digit", an_n, seg_n);
                    end else begin
                        mon_f = exp_q.pop_front();
                        check("digit_an_n",  32'(an_n),  32'(mon_f.an));
                        check("digit_seg_n", 32'(seg_n), 32'(mon_f.seg));
                        check("digit_dp_n",  32'(dp_n),  32'(mon_f.dp));
                    end
                end
                drive_run++;
            end else if (prev_an != 8'hFF) begin
                check("drive_len", 32'(drive_run), 32'd6);
                drive_run = 0;
            end

            if (busy_flash) begin
                busy_run++;
            end else if (prev_busy) begin
                if (busy_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_busy actual run=%0d required none", busy_run);
                end else begin
                    busy_req = busy_exp_q.pop_front();
                    check("busy_len", 32'(busy_run), 32'(busy_req));
                end
                busy_run = 0;
            end
            prev_an   = an_n;
            prev_busy = busy_flash;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] d);
        gpio_we    = 1'b1;
        gpio_wdata = d;
        tick();
        gpio_we    = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_an_n"},  32'(an_n),       32'hFF);
        check({tag, "_seg_n"}, 32'(seg_n),      32'h7F);
        check({tag, "_dp_n"},  32'(dp_n),       32'h1);
        check({tag, "_hex"},   hex_value,       32'h0);
        check({tag, "_busy"},  32'(busy_flash), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b1;
        gpio_we    = 1'b0;
        gpio_wdata = 32'h0;

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_state("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        push_frame(32'h0, 1'b0);
        repeat (64) tick();

        push_frame(32'h0000006F, 1'b1);
        busy_exp_q.push_back(20);
        write(32'h0000006F);
        check("hex_single", hex_value, 32'h0000006F);
        check("busy_set", 32'(busy_flash), 32'h1);
        repeat (62) tick();

        push_frame(32'h0000006F, 1'b1);
        push_frame(32'h0000006F, 1'b0);
        busy_exp_q.push_back(22);
        write(32'h00000001);
        write(32'h00000004);
        write(32'h0000006F);
        check("hex_b2b", hex_value, 32'h0000006F);
        repeat (125) tick();

        push_frame(32'h12345678, 1'b1);
        busy_exp_q.push_back(20);
        write(32'h12345678);
        check("hex_wrap", hex_value, 32'h12345678);
        repeat (63) tick();

        push_frame(32'h00000011, 1'b1);
        busy_exp_q.push_back(20);
        write(32'h00000011);
        repeat (63) tick();

        push_frame(32'h0, 1'b1);
        busy_exp_q.push_back(20);
        write(32'h0);
        check("hex_zero", hex_value, 32'h0);
        repeat (64) tick();

        check("frames_left", 32'(exp_q.size()), 32'd0);
        check("busy_left", 32'(busy_exp_q.size()), 32'd0);

        mon_en = 1'b0;
        write(32'hCAFE0000);
        repeat (3) tick();
        check("pre_reset_an_n", 32'(an_n), 32'hFE);
        check("pre_reset_dp_n", 32'(dp_n), 32'h0);
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset_mid_slot");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
